// File: rtl/link_fsm_spw.sv
// link_fsm_spw: SpaceWire link-level start-up state machine.
// Sequences receiver reset and transmitter NULL/FCT enables up to RUN.
module link_fsm_spw #(
  parameter int CNT_6U4  = 640,
  parameter int CNT_12U8 = 1280,
  parameter int CNT_DISC = 85
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       link_start,
  input  logic       link_disable,
  input  logic       auto_start,
  input  logic       rx_error,
  input  logic       rx_got_bit,
  input  logic       rx_got_null,
  input  logic       rx_got_fct,
  input  logic       rx_got_nchar,
  input  logic       rx_got_time_code,
  input  logic       rx_credit_error,
  output logic       rx_resetn,
  output logic       enable_tx,
  output logic       send_null_tx,
  output logic       send_fct_tx,
  output logic       link_up,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    ERROR_RESET = 3'd0,
    ERROR_WAIT  = 3'd1,
    READY       = 3'd2,
    STARTED     = 3'd3,
    CONNECTING  = 3'd4,
    RUN         = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] timer;
  logic [11:0] dc_cnt;
  logic        dc_armed;
  logic        got_null_flag;
  logic        disconnect;
  logic        err_ev;
  logic        unexp_ev;
  logic        t_6u4;
  logic        t_12u8;
  logic        start_req;

  assign disconnect = dc_armed && (dc_cnt == 12'(CNT_DISC));
  assign err_ev     = rx_error | disconnect | rx_credit_error;
  assign unexp_ev   = rx_got_fct | rx_got_nchar | rx_got_time_code;
  assign t_6u4      = timer == 12'(CNT_6U4 - 1);
  assign t_12u8     = timer == 12'(CNT_12U8 - 1);
  assign start_req  = !link_disable &
                      (link_start | (auto_start & got_null_flag));

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= ERROR_RESET;
    else       state <= state_nxt;
  end

  // Error exits are tested first so they win over progress and timeout.
  always_comb begin
    state_nxt = ERROR_RESET;
    case (state)
      ERROR_RESET:
        state_nxt = t_6u4 ? ERROR_WAIT : ERROR_RESET;
      ERROR_WAIT:
        if (err_ev | unexp_ev) state_nxt = ERROR_RESET;
        else if (t_12u8)       state_nxt = READY;
        else                   state_nxt = ERROR_WAIT;
      READY:
        if (err_ev | unexp_ev) state_nxt = ERROR_RESET;
        else if (start_req)    state_nxt = STARTED;
        else                   state_nxt = READY;
      STARTED:
        if (err_ev | unexp_ev)                  state_nxt = ERROR_RESET;
        else if (got_null_flag | rx_got_null)   state_nxt = CONNECTING;
        else if (t_12u8)                        state_nxt = ERROR_RESET;
        else                                    state_nxt = STARTED;
      CONNECTING:
        if (err_ev | rx_got_nchar | rx_got_time_code)
          state_nxt = ERROR_RESET;
        else if (rx_got_fct) state_nxt = RUN;
        else if (t_12u8)     state_nxt = ERROR_RESET;
        else                 state_nxt = CONNECTING;
      RUN:
        if (err_ev | link_disable) state_nxt = ERROR_RESET;
        else                       state_nxt = RUN;
      default:
        state_nxt = ERROR_RESET;
    endcase
  end

  always_comb begin
    rx_resetn    = state != ERROR_RESET;
    enable_tx    = state inside {STARTED, CONNECTING, RUN};
    send_null_tx = state inside {STARTED, CONNECTING, RUN};
    send_fct_tx  = state inside {CONNECTING, RUN};
    link_up      = state == RUN;
    fsm_state    = state;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset)                   timer <= '0;
    else if (state_nxt != state) timer <= '0;
    else                         timer <= timer + 12'd1;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset)
      got_null_flag <= 1'b0;
    else if (state == ERROR_RESET || state_nxt == ERROR_RESET)
      got_null_flag <= 1'b0;
    else if (rx_got_null)
      got_null_flag <= 1'b1;
  end

  // Counter saturates at CNT_DISC so disconnect stays asserted.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      dc_cnt   <= '0;
      dc_armed <= 1'b0;
    end else if (state == ERROR_RESET || state_nxt == ERROR_RESET) begin
      dc_cnt   <= '0;
      dc_armed <= 1'b0;
    end else if (rx_got_bit) begin
      dc_cnt   <= '0;
      dc_armed <= 1'b1;
    end else if (dc_armed && !disconnect) begin
      dc_cnt   <= dc_cnt + 12'd1;
    end
  end

endmodule
